// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and response type for the data-memory arbiter
package dmem_pkg;
  localparam int DMEM_DEPTH = 1024;
  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;
  localparam bit PORT_CPU = 1'b0;
  localparam bit PORT_AUX = 1'b1;
  typedef struct packed {
    logic rvalid;
    logic err;
    logic [DMEM_DW-1:0] rdata;
  } resp_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter
interface dmem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic req;
  logic we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic err;
  logic [DW-1:0] rdata;
  modport master(output req, we, addr, wdata, input gnt, rvalid, err, rdata);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, ties go to the port not served last
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last
);
  assign gnt[0] = rst & req[0] & (~req[1] | last);
  assign gnt[1] = rst & req[1] & (~req[0] | ~last);
  // remember the most recently granted port; reset favours port 0 on the first tie
  always_ff @(posedge clk)
    if (!rst) last <= PORT_AUX;
    else if (|gnt) last <= gnt[1] ? PORT_AUX : PORT_CPU;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU port and an auxiliary port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);
  logic [1:0] gnt;
  logic last, ir0, ir1;
  resp_t r0, r1;
  assign ir0 = p0.addr < AW'(DEPTH);
  assign ir1 = p1.addr < AW'(DEPTH);
  rr_arbiter2 u_rr (
    .clk(clk),
    .rst(rst),
    .req({p1.req, p0.req}),
    .gnt(gnt),
    .last(last)
  );
  assign p0.gnt = gnt[0];
  assign p1.gnt = gnt[1];
  assign mem_a = gnt[1] ? p1.addr : p0.addr;
  assign mem_wd = gnt[1] ? p1.wdata : p0.wdata;
  assign mem_we = rst & (gnt[1] ? p1.we & ir1 : gnt[0] & p0.we & ir0);
  // one-cycle response per grant; an idle port keeps its last err/rdata
  always_ff @(posedge clk)
    if (!rst) begin
      r0 <= '0;
      r1 <= '0;
    end else begin
      r0.rvalid <= gnt[0];
      r1.rvalid <= gnt[1];
      if (gnt[0]) begin
        r0.err <= ~ir0;
        r0.rdata <= (~p0.we & ir0) ? mem_rd : '0;
      end
      if (gnt[1]) begin
        r1.err <= ~ir1;
        r1.rdata <= (~p1.we & ir1) ? mem_rd : '0;
      end
    end
  assign p0.rvalid = r0.rvalid;
  assign p0.err = r0.err;
  assign p0.rdata = r0.rdata;
  assign p1.rvalid = r1.rvalid;
  assign p1.err = r1.err;
  assign p1.rdata = r1.rdata;
  a_last0: assert property (@(posedge clk) disable iff (!rst) gnt[0] |=> !last);
  a_last1: assert property (@(posedge clk) disable iff (!rst) gnt[1] |=> last);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a memory-level model
module tb_dmem_arbiter;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.AW(32), .DW(32)) p0 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) p1 ();
  logic mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [31:0] ram [1024];
  dmem_arbiter #(.DEPTH(1024), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .p0(p0), .p1(p1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  assign mem_rd = ram[mem_a[9:0]];
  always @(posedge clk) if (mem_we) ram[mem_a[9:0]] <= mem_wd;

  logic [31:0] ref_mem [1024];
  bit pend [2];
  bit pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  bit mlast = 1;
  int last_win;
  logic [32:0] exq0 [$];
  logic [32:0] exq1 [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(int p, bit w, logic [31:0] a, logic [31:0] d);
    pend[p] = 1;
    pw[p] = w;
    pa[p] = a;
    pd[p] = d;
  endtask

  // one clock cycle: drive pending requests, predict the grant and memory effect
  task automatic step(bit r);
    int win;
    bit ir;
    logic [32:0] e;
    @(negedge clk);
    rst = r;
    p0.req = pend[0]; p0.we = pw[0]; p0.addr = pa[0]; p0.wdata = pd[0];
    p1.req = pend[1]; p1.we = pw[1]; p1.addr = pa[1]; p1.wdata = pd[1];
    #1;
    win = -1;
    if (r) begin
      if (pend[0] && pend[1]) win = mlast ? 0 : 1;
      else if (pend[0]) win = 0;
      else if (pend[1]) win = 1;
    end
    chk("gnt", {p1.gnt, p0.gnt}, win < 0 ? 2'b00 : (win == 0 ? 2'b01 : 2'b10));
    if (win < 0) begin
      chk("mem_we_idle", mem_we, 0);
      chk("mem_a_idle", mem_a, pa[0]);
    end else begin
      ir = pa[win] < 32'd1024;
      chk("mem_we", mem_we, pw[win] && ir);
      chk("mem_a", mem_a, pa[win]);
      if (pw[win]) chk("mem_wd", mem_wd, pd[win]);
      e = {!ir, (!pw[win] && ir) ? ref_mem[pa[win][9:0]] : 32'h0};
      if (win == 0) exq0.push_back(e);
      else exq1.push_back(e);
      if (pw[win] && ir) ref_mem[pa[win][9:0]] = pd[win];
      mlast = win[0];
      pend[win] = 0;
    end
    if (!r) mlast = 1;
    last_win = win;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (pend[0] || pend[1]); i++) step(1);
    step(1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(9))
      0: return 32'd1024 + $urandom_range(100);
      1: return 32'hFFFF_FFFF;
      2: return 32'd1023;
      default: return 32'($urandom_range(15));
    endcase
  endfunction

  task automatic mon(int p, logic v, logic er, logic [31:0] rd);
    logic [32:0] e;
    int n;
    n = p == 0 ? exq0.size() : exq1.size();
    if (v) begin
      if (n == 0) chk(p == 0 ? "rvalid0_spurious" : "rvalid1_spurious", v, 0);
      else begin
        e = p == 0 ? exq0.pop_front() : exq1.pop_front();
        chk(p == 0 ? "resp0" : "resp1", {er, rd}, e);
      end
    end else if (n != 0) begin
      chk(p == 0 ? "rvalid0_missing" : "rvalid1_missing", v, 1);
      if (p == 0) void'(exq0.pop_front());
      else void'(exq1.pop_front());
    end
  endtask

  // monitor: responses appear one edge after their grant
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("reset_flags", {p0.rvalid, p1.rvalid, p0.err, p1.err}, 0);
      chk("reset_rdata", {p0.rdata, p1.rdata}, 0);
    end
    mon(0, p0.rvalid, p0.err, p0.rdata);
    mon(1, p1.rvalid, p1.err, p1.rdata);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 0;
      ref_mem[i] = 0;
    end
    p0.req = 0; p0.we = 0; p0.addr = 0; p0.wdata = 0;
    p1.req = 0; p1.we = 0; p1.addr = 0; p1.wdata = 0;
    issue(0, 1, 5, 32'hAA);
    issue(1, 0, 7, 0);
    repeat (3) step(0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (last_win >= 0) issue(last_win, 0, i, 0);
    end
    drain();
    issue(0, 1, 28, 32'h20); drain();
    issue(0, 0, 28, 0); drain();
    issue(1, 1, 40, 32'h2); step(1);
    issue(0, 0, 40, 0); drain();
    issue(0, 1, 0, 32'h1234); drain();
    issue(1, 1, 1024, 32'hDEAD); drain();
    issue(0, 0, 0, 0); drain();
    issue(0, 0, 28, 0); step(1);
    step(0);
    issue(0, 0, 3, 0);
    issue(1, 0, 4, 0);
    drain();
    repeat (3000) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(2) != 0) issue(p, 1'($urandom_range(1)), rand_addr(), $urandom());
      step($urandom_range(199) != 0);
    end
    drain();
    step(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
